// File: rtl/conv_window_feeder.sv
// conv_window_feeder
// Collects one frame (4 kernel weights followed by a 4x4 feature map, row-major)
// from a serial 4-bit stream, then presents the nine 2x2 windows of the map in
// raster order to an external combinational convolution block. It registers the
// result returned for each window.
//
// Frame timeline, with the 20th sample accepted at edge t:
//   [t,   t+1)   LOAD, internal "frame complete", window registers still 0
//   [t+1, t+10)  CONV, window k driven during [t+1+k, t+2+k)
//   [t+2, t+11)  out_valid, result k registered at edge t+2+k
// The state returns to IDLE while the last result is still on out_data. This
// allows the next frame to start in that same cycle.
module conv_window_feeder (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   output logic [3:0] IFM_0,
   output logic [3:0] IFM_1,
   output logic [3:0] IFM_2,
   output logic [3:0] IFM_3,
   output logic [3:0] INW_0,
   output logic [3:0] INW_1,
   output logic [3:0] INW_2,
   output logic [3:0] INW_3,
   input  logic [9:0] Output,
   output logic       out_valid,
   output logic [9:0] out_data,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CONV = 2'd2
   } state_t;

   // The frame is 4 weights followed by 16 pixels. Storage slots 0..3 hold W
   // and slots 4..19 hold P.
   localparam logic [4:0] FRAME_LEN = 5'd20;
   localparam logic [3:0] LAST_WIN  = 4'd8;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [3:0]  win_q, win_d;
   logic        accept;

   // Frame storage. It has no reset: every slot is rewritten before any window
   // is presented.
   logic [3:0]  mem_q [0:19];

   logic [3:0]  ifm_q [0:3];
   logic [3:0]  ifm_d [0:3];
   logic [3:0]  inw_q [0:3];
   logic [3:0]  inw_d [0:3];
   logic        out_valid_q, out_valid_d;
   logic [9:0]  out_data_q, out_data_d;
   logic        win_load;
   logic [3:0]  win_sel;

   // Storage slot of one tap of window 'win' (raster index 0..8 over a 3x3
   // grid of window origins). The origin pixel index is 4*r + c. This equals
   // win + r, where r = win / 3 is resolved by comparisons. Taps 0..3 are at
   // offsets 0, 1, 4 and 5 from the origin, and the pixels start at slot 4.
   function automatic logic [4:0] pix_addr(input logic [3:0] win, input logic [1:0] tap);
      logic [4:0] row_adj;
      logic [4:0] tap_off;
      if (win >= 4'd6)
         row_adj = 5'd2;
      else if (win >= 4'd3)
         row_adj = 5'd1;
      else
         row_adj = 5'd0;
      case (tap)
         2'd0:    tap_off = 5'd0;
         2'd1:    tap_off = 5'd1;
         2'd2:    tap_off = 5'd4;
         default: tap_off = 5'd5;
      endcase
      return 5'd4 + {1'b0, win} + row_adj + tap_off;
   endfunction

   // State, sample counter and window counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         win_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
      end
   end

   // Next-state logic. Samples are accepted only in IDLE (which accepts W[0])
   // and in LOAD until all 20 are in. Input during CONV is ignored.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               cnt_d   = 5'd1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (cnt_q == FRAME_LEN) begin
               state_d = S_CONV;
               cnt_d   = 5'd0;
               win_d   = 4'd0;
            end else if (in_valid) begin
               accept = 1'b1;
               cnt_d  = cnt_q + 5'd1;
            end
         end
         S_CONV: begin
            if (win_q == LAST_WIN) begin
               state_d = S_IDLE;
               win_d   = 4'd0;
            end else begin
               win_d = win_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
            win_d   = 4'd0;
         end
      endcase
   end

   // Output decode: the next window contents and the result capture.
   // Window registers are loaded one cycle ahead of CONV. They therefore
   // always show the window that matches win_q, and they return to zero
   // together with the state.
   always_comb begin
      win_load = 1'b0;
      win_sel  = 4'd0;
      if (state_q == S_LOAD && cnt_q == FRAME_LEN) begin
         win_load = 1'b1;
         win_sel  = 4'd0;
      end else if (state_q == S_CONV && win_q != LAST_WIN) begin
         win_load = 1'b1;
         win_sel  = win_q + 4'd1;
      end
      for (int k = 0; k < 4; k++) begin
         ifm_d[k] = win_load ? mem_q[pix_addr(win_sel, 2'(k))] : 4'd0;
         inw_d[k] = win_load ? mem_q[k] : 4'd0;
      end
      out_valid_d = (state_q == S_CONV);
      out_data_d  = (state_q == S_CONV) ? Output : 10'd0;
   end

   // Frame storage write, addressed by the running sample count.
   always_ff @(posedge clk) begin
      if (accept)
         mem_q[cnt_q] <= in_data;
   end

   // Registered window, weight and result outputs. Reset clears them at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            ifm_q[k] <= 4'd0;
            inw_q[k] <= 4'd0;
         end
         out_valid_q <= 1'b0;
         out_data_q  <= 10'd0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            ifm_q[k] <= ifm_d[k];
            inw_q[k] <= inw_d[k];
         end
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign IFM_0     = ifm_q[0];
   assign IFM_1     = ifm_q[1];
   assign IFM_2     = ifm_q[2];
   assign IFM_3     = ifm_q[3];
   assign INW_0     = inw_q[0];
   assign INW_1     = inw_q[1];
   assign INW_2     = inw_q[2];
   assign INW_3     = inw_q[3];
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 SHALL have no parameters; feature map fixed at 4x4 pixels, kernel at 2x2, pixel/weight 4-bit unsigned.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  qualifies in_data.
REQ-005 SHALL have port: in_data  input  4  serial weight/pixel stream.
REQ-006 SHALL have ports: IFM_0, IFM_1, IFM_2, IFM_3  output  4 each  window pixels to downstream combinational Convolution.
REQ-007 SHALL have ports: INW_0, INW_1, INW_2, INW_3  output  4 each  kernel weights to Convolution.
REQ-008 SHALL have port: Output  input  10  Convolution result for the currently driven window.
REQ-009 SHALL have port: out_valid  output  1  qualifies out_data.
REQ-010 SHALL have port: out_data  output  10  registered convolution result.
REQ-011 SHALL have port: busy  output  1  high in LOAD and CONV states.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, CONV.
REQ-013 IDLE -> LOAD on the first in_valid=1 cycle; that sample is accepted as W[0].
REQ-014 Accept exactly 20 samples: W[0..3], then P[0..15] row-major (P[4r+c] = row r, col c); only in_valid=1 cycles count; gaps pause the count without error.
REQ-015 LOAD -> CONV on the cycle after the 20th sample is accepted.
REQ-016 In CONV, present one window per cycle for 9 cycles, raster order (r,c) = (0,0),(0,1),(0,2),(1,0) ... (2,2).
REQ-017 Window (r,c): IFM_0=P[r][c], IFM_1=P[r][c+1], IFM_2=P[r+1][c], IFM_3=P[r+1][c+1]; INW_k=W[k] for k=0..3.
REQ-018 IFM_x and INW_x SHALL be registered, and SHALL be 0 in IDLE and LOAD.
REQ-019 out_data SHALL capture Output at the end of each CONV cycle; out_valid=1 in the following cycle.
REQ-020 Latency: 20th sample accepted at edge t -> first window driven t+1..t+2 -> first out_valid t+2..t+3; 9 out_valid pulses on consecutive cycles.
REQ-021 out_valid=0 and out_data=0 in every cycle not carrying a result.
REQ-022 CONV -> IDLE after the 9th window; a new frame may begin with in_valid on the cycle the 9th result is output.
REQ-023 in_valid during CONV SHALL be ignored (no storage update, no counter change).
REQ-024 Output is treated as 10-bit unsigned with no saturation or truncation; the maximum 4*15*15 = 900 fits.
REQ-025 Weight and pixel storage SHALL be overwritten per frame; no state carries over between frames other than storage contents.

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, counters 0, busy=0, out_valid=0, out_data=0, all IFM_x/INW_x=0.
REQ-027 Reset asserted mid-LOAD or mid-CONV SHALL abort the frame; no further out_valid until a full new 20-sample frame completes.
REQ-028 Storage contents need not be cleared by reset, but they SHALL never reach outputs before being rewritten.

Verification
REQ-029 W={1,1,1,1}, P[i]=i, contiguous in_valid -> out_data sequence 10,14,18,26,30,34,42,46,50 on 9 consecutive cycles.
REQ-030 W={15,15,15,15}, all P=15 -> nine results of 900, with no overflow.
REQ-031 W={1,0,0,0}, P[i]=i, random in_valid gaps in LOAD -> 0,1,2,4,5,6,8,9,10; result independent of gap pattern.
REQ-032 Toggle in_valid with random data throughout CONV -> outputs identical to REQ-029; busy=1 for exactly 9 CONV cycles after LOAD.
REQ-033 Assert rst after the 4th out_valid -> all outputs 0 the same cycle; send a new frame (REQ-030 data) -> exactly nine results of 900.
REQ-034 Send back-to-back frames (REQ-029 data, then REQ-031 data) starting per REQ-022 -> both sequences correct, second unaffected by first.
